// File: rtl/bpred_ftq_pkg.sv
// ============================================================================
// Module      : bpred_ftq_pkg
// Description : Shared types and constants for the fetch target queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bpred_ftq_pkg;

   localparam int FTQ_XLEN   = 64;
   localparam int FTQ_CLASSW = 4;

   // Bit positions inside the one-hot class field {call, return, jump, branch}
   localparam int CLS_BRANCH = 0;
   localparam int CLS_JUMP   = 1;
   localparam int CLS_RETURN = 2;
   localparam int CLS_CALL   = 3;

   typedef struct packed {
      logic [FTQ_XLEN-1:0]   pc;
      logic [FTQ_XLEN-1:0]   bta;
      logic [FTQ_CLASSW-1:0] cls;
      logic [1:0]            dir;
   } ftq_entry_t;

endpackage

`default_nettype wire

// File: rtl/bpred_ftq_ptr.sv
// ============================================================================
// Module      : ftq_ptr
// Description : Wrap-bit queue pointer with increment, load and sync reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ftq_ptr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_inc,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic [W-1:0] o_ptr
);

   logic [W-1:0] r_ptr;

   // A load (redirect) overrides a same-cycle increment
   always_ff @(posedge clk) begin
      if (reset)
         r_ptr <= '0;
      else if (i_load)
         r_ptr <= i_load_val;
      else if (i_inc)
         r_ptr <= r_ptr + W'(1);
   end

   assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/bpred_ftq.sv
// ============================================================================
// Module      : bpred_ftq
// Description : Fetch target queue between branch predictor and fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpred_ftq
   import bpred_ftq_pkg::*;
#(
   parameter  int XLEN   = 64,
   parameter  int DEPTH  = 8,
   parameter  int CLASSW = 4,
   localparam int IDXW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              EnqValidF,
   output logic              EnqReadyF,
   input  logic [XLEN-1:0]   EnqPCF,
   input  logic [XLEN-1:0]   EnqBTAF,
   input  logic [CLASSW-1:0] EnqClassF,
   input  logic [1:0]        EnqDirF,
   output logic              FetchValidF,
   input  logic              FetchReadyF,
   output logic [XLEN-1:0]   FetchPCF,
   output logic [XLEN-1:0]   FetchBTAF,
   output logic [IDXW-1:0]   FetchIdxF,
   input  logic              RedirectE,
   input  logic [IDXW-1:0]   RedirectIdxE,
   input  logic              CommitM,
   output logic              UpdValidW,
   output logic [XLEN-1:0]   UpdPCW,
   output logic [XLEN-1:0]   UpdBTAW,
   output logic [CLASSW-1:0] UpdClassW,
   output logic [1:0]        UpdDirW,
   output logic [IDXW:0]     CountF,
   output logic              OverflowErr
);

   logic [IDXW:0]   w_e, w_p, w_c;
   logic [IDXW:0]   w_count, w_window, w_redir_ptr;
   logic [IDXW-1:0] w_off;
   logic            w_full, w_empty, w_enq, w_fetch, w_commit, w_redir_ok;
   ftq_entry_t      w_wr;

   ftq_entry_t      r_mem [DEPTH];
   ftq_entry_t      r_upd;
   logic            r_upd_valid;
   logic            r_err;

   assign w_count = w_e - w_c;
   assign w_full  = (w_count == (IDXW+1)'(DEPTH));
   assign w_empty = (w_e == w_c);

   assign EnqReadyF   = ~w_full & ~RedirectE;
   assign w_enq       = EnqValidF & EnqReadyF;
   assign FetchValidF = (w_p != w_e);

   // Locate the redirect tag as an offset from the commit pointer; it is
   // legal only if it falls among the already-fetched entries [C, P).
   assign w_off       = RedirectIdxE - w_c[IDXW-1:0];
   assign w_window    = w_p - w_c;
   assign w_redir_ok  = RedirectE & ({1'b0, w_off} < w_window);
   assign w_redir_ptr = w_c + {1'b0, w_off} + (IDXW+1)'(1);

   assign w_fetch  = FetchValidF & FetchReadyF & ~w_redir_ok;
   assign w_commit = CommitM & ~w_empty;

   ftq_ptr #(.W(IDXW+1)) u_enq_ptr (
      .clk(clk), .reset(reset), .i_inc(w_enq), .i_load(w_redir_ok),
      .i_load_val(w_redir_ptr), .o_ptr(w_e)
   );

   ftq_ptr #(.W(IDXW+1)) u_fetch_ptr (
      .clk(clk), .reset(reset), .i_inc(w_fetch), .i_load(w_redir_ok),
      .i_load_val(w_redir_ptr), .o_ptr(w_p)
   );

   ftq_ptr #(.W(IDXW+1)) u_commit_ptr (
      .clk(clk), .reset(reset), .i_inc(w_commit), .i_load(1'b0),
      .i_load_val('0), .o_ptr(w_c)
   );

   always_comb begin
      w_wr     = '0;
      w_wr.pc  = FTQ_XLEN'(EnqPCF);
      w_wr.bta = FTQ_XLEN'(EnqBTAF);
      w_wr.cls = FTQ_CLASSW'(EnqClassF);
      w_wr.dir = EnqDirF;
   end

   always_ff @(posedge clk) begin
      if (w_enq)
         r_mem[w_e[IDXW-1:0]] <= w_wr;
   end

   always_ff @(posedge clk) begin
      if (w_commit)
         r_upd <= r_mem[w_c[IDXW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_upd_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_upd_valid <= w_commit;
         if ((CommitM & w_empty) | (RedirectE & ~w_redir_ok))
            r_err <= 1'b1;
      end
   end

   assign FetchPCF    = r_mem[w_p[IDXW-1:0]].pc[XLEN-1:0];
   assign FetchBTAF   = r_mem[w_p[IDXW-1:0]].bta[XLEN-1:0];
   assign FetchIdxF   = w_p[IDXW-1:0];
   assign UpdValidW   = r_upd_valid;
   assign UpdPCW      = r_upd.pc[XLEN-1:0];
   assign UpdBTAW     = r_upd.bta[XLEN-1:0];
   assign UpdClassW   = r_upd.cls[CLASSW-1:0];
   assign UpdDirW     = r_upd.dir;
   assign CountF      = w_count;
   assign OverflowErr = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bpred_ftq.sv
// ============================================================================
// Module      : tb_bpred_ftq
// Description : Directed self-checking bench for bpred_ftq at DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bpred_ftq;

   localparam int XLEN   = 64;
   localparam int DEPTH  = 4;
   localparam int CLASSW = 4;
   localparam int IDXW   = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              EnqValidF, EnqReadyF;
   logic [XLEN-1:0]   EnqPCF, EnqBTAF;
   logic [CLASSW-1:0] EnqClassF;
   logic [1:0]        EnqDirF;
   logic              FetchValidF, FetchReadyF;
   logic [XLEN-1:0]   FetchPCF, FetchBTAF;
   logic [IDXW-1:0]   FetchIdxF;
   logic              RedirectE;
   logic [IDXW-1:0]   RedirectIdxE;
   logic              CommitM;
   logic              UpdValidW;
   logic [XLEN-1:0]   UpdPCW, UpdBTAW;
   logic [CLASSW-1:0] UpdClassW;
   logic [1:0]        UpdDirW;
   logic [IDXW:0]     CountF;
   logic              OverflowErr;

   int n_checks = 0;
   int n_errors = 0;

   bpred_ftq #(.XLEN(XLEN), .DEPTH(DEPTH), .CLASSW(CLASSW)) dut (
      .clk(clk), .reset(reset),
      .EnqValidF(EnqValidF), .EnqReadyF(EnqReadyF), .EnqPCF(EnqPCF),
      .EnqBTAF(EnqBTAF), .EnqClassF(EnqClassF), .EnqDirF(EnqDirF),
      .FetchValidF(FetchValidF), .FetchReadyF(FetchReadyF),
      .FetchPCF(FetchPCF), .FetchBTAF(FetchBTAF), .FetchIdxF(FetchIdxF),
      .RedirectE(RedirectE), .RedirectIdxE(RedirectIdxE), .CommitM(CommitM),
      .UpdValidW(UpdValidW), .UpdPCW(UpdPCW), .UpdBTAW(UpdBTAW),
      .UpdClassW(UpdClassW), .UpdDirW(UpdDirW), .CountF(CountF),
      .OverflowErr(OverflowErr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic enq(input logic [63:0] pc, input logic [63:0] bta, input logic [1:0] dir);
      EnqValidF = 1'b1;
      EnqPCF    = pc;
      EnqBTAF   = bta;
      EnqClassF = 4'b0001;
      EnqDirF   = dir;
      tick();
      EnqValidF = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; EnqValidF = 1'b0; EnqPCF = '0; EnqBTAF = '0;
      EnqClassF = '0; EnqDirF = '0; FetchReadyF = 1'b0;
      RedirectE = 1'b0; RedirectIdxE = '0; CommitM = 1'b0;
      do_reset();

      chk("rst_count", 64'(CountF), 64'd0);
      chk("rst_fvalid", 64'(FetchValidF), 64'd0);
      chk("rst_updvalid", 64'(UpdValidW), 64'd0);
      chk("rst_err", 64'(OverflowErr), 64'd0);
      chk("rst_enqready", 64'(EnqReadyF), 64'd1);

      // Fill / drain
      for (int i = 0; i < 4; i++) enq(64'h100 + 64'(4*i), 64'h200 + 64'(i), 2'(i));
      chk("fill_count", 64'(CountF), 64'd4);
      chk("fill_ready", 64'(EnqReadyF), 64'd0);
      enq(64'h110, 64'h210, 2'd0);
      chk("fifth_count", 64'(CountF), 64'd4);
      FetchReadyF = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("fetch_valid", 64'(FetchValidF), 64'd1);
         chk("fetch_pc", FetchPCF, 64'h100 + 64'(4*i));
         tick();
      end
      FetchReadyF = 1'b0;
      chk("drain_fvalid", 64'(FetchValidF), 64'd0);

      // Commit training
      CommitM = 1'b1;
      tick();
      chk("upd0_valid", 64'(UpdValidW), 64'd1);
      chk("upd0_pc", UpdPCW, 64'h100);
      chk("upd0_bta", UpdBTAW, 64'h200);
      chk("upd0_dir", 64'(UpdDirW), 64'd0);
      tick();
      CommitM = 1'b0;
      chk("upd1_valid", 64'(UpdValidW), 64'd1);
      chk("upd1_pc", UpdPCW, 64'h104);
      chk("upd1_class", 64'(UpdClassW), 64'h1);
      tick();
      chk("upd_pulse", 64'(UpdValidW), 64'd0);
      chk("commit_count", 64'(CountF), 64'd2);

      // Redirect squash
      do_reset();
      for (int i = 0; i < 4; i++) enq(64'h300 + 64'(4*i), 64'h0, 2'd1);
      FetchReadyF = 1'b1;
      repeat (4) tick();
      FetchReadyF = 1'b0;
      RedirectE = 1'b1; RedirectIdxE = 2'd1;
      EnqValidF = 1'b1; EnqPCF = 64'h400;
      #1;
      chk("redir_enqready", 64'(EnqReadyF), 64'd0);
      tick();
      RedirectE = 1'b0; EnqValidF = 1'b0;
      chk("redir_count", 64'(CountF), 64'd2);
      chk("redir_fvalid", 64'(FetchValidF), 64'd0);
      enq(64'h400, 64'h0, 2'd0);
      chk("redir_new_valid", 64'(FetchValidF), 64'd1);
      chk("redir_new_pc", FetchPCF, 64'h400);
      chk("redir_new_idx", 64'(FetchIdxF), 64'd2);
      chk("redir_err", 64'(OverflowErr), 64'd0);

      // Wrap-around rounds
      do_reset();
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 4; k++) enq(64'h1000 + 64'(16*r + 4*k), 64'h0, 2'd0);
         chk("wrap_full_count", 64'(CountF), 64'd4);
         chk("wrap_full_ready", 64'(EnqReadyF), 64'd0);
         FetchReadyF = 1'b1;
         repeat (4) tick();
         FetchReadyF = 1'b0;
         CommitM = 1'b1;
         for (int k = 0; k < 4; k++) begin
            tick();
            chk("wrap_upd_pc", UpdPCW, 64'h1000 + 64'(16*r + 4*k));
         end
         CommitM = 1'b0;
         chk("wrap_empty_count", 64'(CountF), 64'd0);
         chk("wrap_empty_ready", 64'(EnqReadyF), 64'd1);
      end

      // Commit and redirect in the same cycle on the oldest entry
      do_reset();
      for (int i = 0; i < 3; i++) enq(64'h500 + 64'(4*i), 64'h0, 2'd2);
      FetchReadyF = 1'b1;
      repeat (3) tick();
      FetchReadyF = 1'b0;
      CommitM = 1'b1; RedirectE = 1'b1; RedirectIdxE = 2'd0;
      tick();
      CommitM = 1'b0; RedirectE = 1'b0;
      chk("cr_count", 64'(CountF), 64'd0);
      chk("cr_upd_valid", 64'(UpdValidW), 64'd1);
      chk("cr_upd_pc", UpdPCW, 64'h500);
      chk("cr_err", 64'(OverflowErr), 64'd0);
      chk("cr_fvalid", 64'(FetchValidF), 64'd0);

      // Commit while empty
      CommitM = 1'b1;
      tick();
      CommitM = 1'b0;
      chk("empty_commit_err", 64'(OverflowErr), 64'd1);
      chk("empty_commit_noupd", 64'(UpdValidW), 64'd0);
      tick();
      tick();
      chk("err_sticky", 64'(OverflowErr), 64'd1);

      // Reset with entries present and an update in flight
      for (int i = 0; i < 3; i++) enq(64'h600 + 64'(4*i), 64'h0, 2'd0);
      chk("pre_rst_count", 64'(CountF), 64'd3);
      CommitM = 1'b1;
      tick();
      CommitM = 1'b0;
      chk("pre_rst_upd", 64'(UpdValidW), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_count", 64'(CountF), 64'd0);
      chk("midrst_fvalid", 64'(FetchValidF), 64'd0);
      chk("midrst_upd", 64'(UpdValidW), 64'd0);
      chk("midrst_err", 64'(OverflowErr), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bpred_ftq.md
Name: bpred_ftq

Overview:
- Parametrised fetch target queue that decouples the branch predictor from the fetch pipeline.
- The predictor enqueues one prediction block per cycle: fetch PC, predicted target, class and direction. Fetch consumes blocks in order.
- Entries are held until the covered instruction commits in M, then replayed to the predictor as training data.
- An E-stage mispredict squashes every entry younger than the offending one and redirects fetch, so the predictor can run ahead of a stalled fetch.

Parameters:
- XLEN, 64, address width.
- DEPTH, 8, number of entries; power of two, minimum 2.
- CLASSW, 4, instruction-class width; one-hot {call, return, jump, branch}.
- IDXW, $clog2(DEPTH), entry index width (derived, not overridable).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- EnqValidF  in  1  predictor offers an entry
- EnqReadyF  out  1  queue accepts the entry
- EnqPCF  in  XLEN  block fetch address
- EnqBTAF  in  XLEN  predicted target
- EnqClassF  in  CLASSW  predicted class
- EnqDirF  in  2  predicted 2-bit counter state
- FetchValidF  out  1  an unfetched entry exists
- FetchReadyF  in  1  fetch consumes the head-of-fetch entry
- FetchPCF  out  XLEN  entry fetch address
- FetchBTAF  out  XLEN  entry predicted target
- FetchIdxF  out  IDXW  entry tag, carried down the pipeline with the instruction
- RedirectE  in  1  mispredict resolved in E
- RedirectIdxE  in  IDXW  tag of the mispredicted instruction
- CommitM  in  1  instruction with the oldest tag retires from M
- UpdValidW  out  1  training record valid
- UpdPCW  out  XLEN  retired entry PC
- UpdBTAW  out  XLEN  retired entry target
- UpdClassW  out  CLASSW  retired entry class
- UpdDirW  out  2  retired entry direction state
- CountF  out  IDXW+1  occupied entries
- OverflowErr  out  1  sticky protocol error

Behaviour:
- Pointers:
  - Three pointers, each IDXW+1 bits wide with a wrap bit: enq (E), fetch (P), commit (C).
  - Invariant: C ≤ P ≤ E ≤ C+DEPTH, all modulo 2^(IDXW+1).
- Reset:
  - E = P = C = 0.
  - UpdValidW = 0, OverflowErr = 0, CountF = 0.
  - Entry storage is not reset.
- Status:
  - Full = (E−C == DEPTH). Empty = (E == C).
  - CountF = E−C, combinational from the registered pointers.
- Enqueue:
  - EnqReadyF = ~Full & ~RedirectE.
  - On EnqValidF & EnqReadyF: write entry[E[IDXW−1:0]] and set E ← E+1.
- Fetch:
  - FetchValidF = (P != E). Outputs read entry[P] combinationally.
  - On FetchValidF & FetchReadyF: P ← P+1.
  - No enqueue-to-fetch bypass: an enqueued entry appears on FetchValidF no earlier than the next cycle.
- Redirect (highest priority):
  - Let R = the pointer whose index is RedirectIdxE, chosen in the window [C, P).
  - E ← R+1 and P ← R+1. The same-cycle enqueue and fetch-advance are suppressed.
  - The entry at R is kept so that it trains with its predicted fields. Its own redirect target comes from the existing correction mux, not from this block.
- Commit:
  - On CommitM & ~Empty: C ← C+1.
  - On the next cycle, UpdValidW = 1 and the Upd* outputs hold the entry just freed (registered, latency 1).
  - UpdValidW is a one-cycle pulse per commit.
- Simultaneous events:
  - Commit together with redirect: both apply. Commit updates C; redirect updates E and P.
  - If RedirectIdxE equals C's index in a commit cycle, E = P = C_old+1 = C_new and the queue becomes empty.
- Error cases:
  - Wrap-around: the index is the low IDXW bits. Full and empty are distinguished only by the wrap bit.
  - CommitM while Empty: ignored and OverflowErr set.
  - RedirectIdxE outside [C, P): ignored and OverflowErr set.
  - OverflowErr clears only on reset.
- Reset mid-operation: all pointers return to 0 on the next edge, the queue is empty, and an in-flight UpdValidW is dropped.

Decomposition:
- Shared package (cvw):
  - ftq_entry_t struct: pc, bta, class, dir.
  - Class-bit index constants (CALL, RETURN, JUMP, BRANCH).
- One sub-module, ftq_ptr:
  - Parametrised wrap-bit pointer register with inc, load and synchronous reset.
  - Instantiated three times.
- Storage: flop array indexed by pointer low bits, written only through the enqueue port.

Test Plan:
- Fill/drain, DEPTH=4: enqueue PCs 0x100, 0x104, 0x108, 0x10C, with FetchReadyF=0 → CountF=4, EnqReadyF=0. A fifth offer is not accepted. Then four fetches → FetchPCF returns 0x100..0x10C in order.
- Commit training: after the fill, CommitM on 2 cycles → UpdValidW pulses on the following 2 cycles with UpdPCW=0x100, then 0x104. CountF=2.
- Redirect squash: entries at indices 0-3 with P=4, C=0. RedirectE with idx=1 → E=P=2, FetchValidF=0. An EnqValidF in the same cycle sees EnqReadyF=0. The next enqueue writes index 2.
- Wrap-around: 10 enqueue/fetch/commit rounds at DEPTH=4 → Full and Empty stay correct across the wrap bit, and UpdPCW order matches enqueue order.
- Commit+redirect same cycle: C=0, P=3, RedirectIdxE=0 with CommitM → CountF=0, UpdPCW = entry 0 next cycle, OverflowErr=0.
- Error and reset: CommitM while empty → OverflowErr=1 and stays 1. Reset asserted with 3 entries present → the next cycle shows CountF=0, FetchValidF=0, UpdValidW=0, OverflowErr=0.
